// File: rtl/pattern_resp_misr.sv
// pattern_resp_misr: MISR response compactor with warm-up flush, sample capture and golden compare.
// Optional macro TOGGLE_CNT_EN adds a saturating toggle_cnt output counting response changes.
module pattern_resp_misr #(
  parameter int unsigned      RESP_W = 9,
  parameter int unsigned      SIG_W  = 16,
  parameter int unsigned      CNT_W  = 16,
  parameter int unsigned      WARMUP = 4,
  parameter logic [SIG_W-1:0] POLY   = 16'h002D
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [SIG_W-1:0]  golden_sig,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_cnt
`ifdef TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0]  toggle_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CAPTURE, S_DONE} state_t;

  // Warm-up counter runs 0..WARMUP-1; the last value marks the exit edge.
  localparam logic [7:0] WARM_LAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_t             state_q, state_d;
  logic [7:0]         warm_q, warm_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [SIG_W-1:0]   golden_q, golden_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pass_q, pass_d;

  logic               abort_run;
  logic               accept;
  logic [SIG_W-1:0]   resp_ext;
  logic [SIG_W-1:0]   fold_sig;
  logic [CNT_W-1:0]   cnt_inc;

  assign abort_run = abort && (state_q != S_IDLE);
  assign accept    = start && !abort_run && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    num_d    = num_q;
    golden_d = golden_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;

    resp_ext = '0;
    resp_ext[RESP_W-1:0] = resp_in;
    fold_sig = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
    cnt_inc  = cnt_q + 1'b1;

    if (abort_run) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else if (accept) begin
      num_d    = num_samples;
      golden_d = golden_sig;
      sig_d    = '0;
      cnt_d    = '0;
      warm_d   = '0;
      pass_d   = 1'b0;
      // With no warm-up, an empty run must finish at once or the counter would wrap.
      if (WARMUP != 0) begin
        state_d = S_WARMUP;
      end else if (num_samples == '0) begin
        state_d = S_DONE;
        pass_d  = (golden_sig == '0);
      end else begin
        state_d = S_CAPTURE;
      end
    end else begin
      case (state_q)
        S_WARMUP: begin
          if (warm_q == WARM_LAST) begin
            if (num_q == '0) begin
              state_d = S_DONE;
              pass_d  = (golden_q == '0);
            end else begin
              state_d = S_CAPTURE;
            end
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (resp_valid) begin
            sig_d = fold_sig;
            cnt_d = cnt_inc;
            if (cnt_inc == num_q) begin
              state_d = S_DONE;
              pass_d  = (fold_sig == golden_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state_q  <= S_IDLE;
      warm_q   <= '0;
      num_q    <= '0;
      golden_q <= '0;
      sig_q    <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      num_q    <= num_d;
      golden_q <= golden_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
    end
  end

  assign busy       = (state_q == S_WARMUP) || (state_q == S_CAPTURE);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q && done;
  assign signature  = sig_q;
  assign sample_cnt = cnt_q;

`ifdef TOGGLE_CNT_EN
  logic [CNT_W-1:0]  toggle_q, toggle_d;
  logic [RESP_W-1:0] prev_q, prev_d;

  // The previous-sample register starts at zero so the first sample compares against 0.
  always_comb begin
    toggle_d = toggle_q;
    prev_d   = prev_q;
    if (accept) begin
      toggle_d = '0;
      prev_d   = '0;
    end else if (!abort_run && (state_q == S_CAPTURE) && resp_valid) begin
      prev_d = resp_in;
      if ((resp_in != prev_q) && (toggle_q != '1)) begin
        toggle_d = toggle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      toggle_q <= '0;
      prev_q   <= '0;
    end else begin
      toggle_q <= toggle_d;
      prev_q   <= prev_d;
    end
  end

  assign toggle_cnt = toggle_q;
`endif

endmodule

// File: tb/tb_pattern_resp_misr.sv
// tb_pattern_resp_misr: table-driven, directed and randomized checks of pattern_resp_misr
// against a run-level reference model.
module tb_pattern_resp_misr;

  localparam int unsigned WARMUP = 4;
  localparam int unsigned POLY_V = 'h2D;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_samples;
  logic [15:0] golden_sig;
  logic        resp_valid;
  logic [8:0]  resp_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] sample_cnt;
`ifdef TOGGLE_CNT_EN
  logic [15:0] toggle_cnt;
`endif

  pattern_resp_misr dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .start          (start),
    .abort          (abort),
    .num_samples    (num_samples),
    .golden_sig     (golden_sig),
    .resp_valid     (resp_valid),
    .resp_in        (resp_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .signature      (signature),
    .sample_cnt     (sample_cnt)
`ifdef TOGGLE_CNT_EN
    ,
    .toggle_cnt     (toggle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Run-level reference: "running" covers warm-up and capture, "finished" is the done phase.
  bit          m_run, m_fin, m_pass;
  int unsigned m_warm, m_num, m_gold, m_sig, m_cnt, m_tog, m_prev;

  typedef struct {
    bit          st;
    bit          ab;
    logic [15:0] nm;
    logic [15:0] gd;
    bit          v;
    logic [8:0]  r;
    bit          e_busy;
    bit          e_done;
    bit          e_pass;
    logic [15:0] e_sig;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[8];
  int   gap_valid[6] = '{1, 0, 0, 1, 0, 1};
  int   gap_cnt[6]   = '{1, 1, 1, 2, 2, 3};

  function automatic int unsigned fold(input int unsigned s, input int unsigned r);
    int unsigned t;
    t = s * 2;
    if (t >= 65536) t = (t - 65536) ^ POLY_V;
    return t ^ r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int unsigned exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_run = 0; m_fin = 0; m_pass = 0;
    m_warm = 0; m_num = 0; m_gold = 0; m_sig = 0; m_cnt = 0; m_tog = 0; m_prev = 0;
  endtask

  task automatic modelEdge(input bit st, input bit ab, input int unsigned nm,
                           input int unsigned gd, input bit v, input int unsigned r);
    if (ab && (m_run || m_fin)) begin
      m_run = 0; m_fin = 0; m_pass = 0;
    end else if (st && !m_run) begin
      m_num = nm; m_gold = gd; m_sig = 0; m_cnt = 0; m_tog = 0; m_prev = 0;
      m_pass = 0; m_fin = 0; m_run = 1; m_warm = WARMUP;
      if (WARMUP == 0 && nm == 0) begin
        m_run = 0; m_fin = 1; m_pass = (gd == 0);
      end
    end else if (m_run && m_warm > 0) begin
      m_warm--;
      if (m_warm == 0 && m_num == 0) begin
        m_run = 0; m_fin = 1; m_pass = (m_gold == 0);
      end
    end else if (m_run && v) begin
      m_sig = fold(m_sig, r);
      m_cnt++;
      if (r != m_prev && m_tog < 65535) m_tog++;
      m_prev = r;
      if (m_cnt == m_num) begin
        m_run = 0; m_fin = 1; m_pass = (m_sig == m_gold);
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_busy"}, 32'(busy), m_run);
    chk({tag, "_done"}, 32'(done), m_fin);
    chk({tag, "_pass"}, 32'(pass), (m_pass && m_fin) ? 1 : 0);
    chk({tag, "_sig"},  32'(signature), m_sig);
    chk({tag, "_cnt"},  32'(sample_cnt), m_cnt);
`ifdef TOGGLE_CNT_EN
    chk({tag, "_tog"},  32'(toggle_cnt), m_tog);
`endif
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input logic [15:0] nm,
                               input logic [15:0] gd, input bit v, input logic [8:0] r);
    start = st; abort = ab; num_samples = nm; golden_sig = gd; resp_valid = v; resp_in = r;
    @(posedge clk);
    modelEdge(st, ab, nm, gd, v, r);
    #1;
    checkOutput("model");
  endtask

  task automatic checkZeros(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_sig"},  32'(signature), 0);
    chk({tag, "_cnt"},  32'(sample_cnt), 0);
  endtask

  task automatic releaseReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bit          st, ab, v;
    logic [15:0] nm, gd;
    logic [8:0]  r;

    rst_n = 1'b0;
    start = 0; abort = 0; num_samples = '0; golden_sig = '0; resp_valid = 0; resp_in = '0;
    modelReset();
    #1;
    checkZeros("rst_hold");
    releaseReset();
    checkZeros("rst_idle");

    // Basic fold: two samples of 0x001 against golden 0x0003.
    tbl[0] = '{1, 0, 16'd2, 16'h0003, 1, 9'h001, 1, 0, 0, 16'h0000, 16'd0};
    tbl[1] = '{0, 0, 16'd0, 16'h0000, 1, 9'h001, 1, 0, 0, 16'h0000, 16'd0};
    tbl[2] = '{0, 0, 16'd0, 16'h0000, 1, 9'h001, 1, 0, 0, 16'h0000, 16'd0};
    tbl[3] = '{0, 0, 16'd0, 16'h0000, 1, 9'h001, 1, 0, 0, 16'h0000, 16'd0};
    tbl[4] = '{0, 0, 16'd0, 16'h0000, 1, 9'h001, 1, 0, 0, 16'h0000, 16'd0};
    tbl[5] = '{0, 0, 16'd0, 16'h0000, 1, 9'h001, 1, 0, 0, 16'h0001, 16'd1};
    tbl[6] = '{0, 0, 16'd0, 16'h0000, 1, 9'h001, 0, 1, 1, 16'h0003, 16'd2};
    tbl[7] = '{0, 0, 16'd0, 16'h0000, 0, 9'h000, 0, 1, 1, 16'h0003, 16'd2};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].st, tbl[i].ab, tbl[i].nm, tbl[i].gd, tbl[i].v, tbl[i].r);
      chk("tbl_busy", 32'(busy), tbl[i].e_busy);
      chk("tbl_done", 32'(done), tbl[i].e_done);
      chk("tbl_pass", 32'(pass), tbl[i].e_pass);
      chk("tbl_sig",  32'(signature), tbl[i].e_sig);
      chk("tbl_cnt",  32'(sample_cnt), tbl[i].e_cnt);
    end

    // Feedback wrap, restarted from DONE: 0x100 walks to the MSB and folds in the polynomial.
    applyStimulus(1, 0, 16'd9, 16'h002C, 1, 9'h100);
    repeat (WARMUP) applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h100);
    applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h100);
    repeat (7) applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h000);
    chk("wrap_sig8", 32'(signature), 'h8000);
    chk("wrap_done8", 32'(done), 0);
    applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h000);
    chk("wrap_sig9", 32'(signature), 'h002D);
    chk("wrap_done9", 32'(done), 1);
    chk("wrap_pass", 32'(pass), 0);

    // Valid gaps: the counter only moves on qualified cycles.
    applyStimulus(1, 0, 16'd3, 16'h0, 0, 9'h000);
    repeat (WARMUP) applyStimulus(0, 0, 16'd0, 16'h0, 0, 9'h000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 16'd0, 16'h0, gap_valid[i] != 0, 9'($urandom_range(0, 511)));
      chk("gap_cnt", 32'(sample_cnt), gap_cnt[i]);
      chk("gap_done", 32'(done), (i == 5) ? 1 : 0);
    end

    // Zero samples: done right after warm-up, pass reflects golden==0.
    applyStimulus(1, 0, 16'd0, 16'h0000, 1, 9'h1FF);
    repeat (WARMUP - 1) applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h1FF);
    chk("zero_busy", 32'(busy), 1);
    applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h1FF);
    chk("zero_done", 32'(done), 1);
    chk("zero_sig", 32'(signature), 0);
    chk("zero_pass", 32'(pass), 1);
    applyStimulus(1, 0, 16'd0, 16'h0005, 0, 9'h000);
    repeat (WARMUP) applyStimulus(0, 0, 16'd0, 16'h0, 0, 9'h000);
    chk("zero_pass_bad", 32'(pass), 0);

    // Abort in capture at five samples, then abort in IDLE.
    applyStimulus(1, 0, 16'd20, 16'h0, 1, 9'h055);
    repeat (WARMUP + 5) applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h055);
    chk("abort_pre_cnt", 32'(sample_cnt), 5);
    applyStimulus(0, 1, 16'd0, 16'h0, 1, 9'h055);
    chk("abort_cnt", 32'(sample_cnt), 5);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    applyStimulus(0, 1, 16'd0, 16'h0, 1, 9'h055);
    chk("abort_idle_cnt", 32'(sample_cnt), 5);

    // Reset at sample 2 clears everything without waiting for a clock edge.
    applyStimulus(1, 0, 16'd10, 16'h0, 1, 9'h0F0);
    repeat (WARMUP + 2) applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h0F0);
    chk("midrst_pre_cnt", 32'(sample_cnt), 2);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkZeros("midrst");
    releaseReset();
    checkZeros("midrst_idle");

    // Toggle sequence 0x001,0x001,0x002 folds to 0x0004.
    applyStimulus(1, 0, 16'd3, 16'h0004, 1, 9'h001);
    repeat (WARMUP) applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h001);
    applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h001);
    applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h001);
    applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h002);
    chk("tog_sig", 32'(signature), 'h0004);
    chk("tog_pass", 32'(pass), 1);
`ifdef TOGGLE_CNT_EN
    chk("tog_cnt", 32'(toggle_cnt), 2);
`endif

    // Restart from DONE with new latched values, then abort beats start in DONE.
    applyStimulus(1, 0, 16'd1, 16'h00AB, 1, 9'h0AB);
    chk("restart_sig_clr", 32'(signature), 0);
    chk("restart_cnt_clr", 32'(sample_cnt), 0);
    repeat (WARMUP + 1) applyStimulus(0, 0, 16'd0, 16'h0, 1, 9'h0AB);
    chk("restart_sig", 32'(signature), 'h00AB);
    chk("restart_done", 32'(done), 1);
    chk("restart_pass", 32'(pass), 1);
    applyStimulus(1, 1, 16'd4, 16'h0, 1, 9'h0AB);
    chk("prio_busy", 32'(busy), 0);
    chk("prio_done", 32'(done), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 24) == 0);
      nm = 16'($urandom_range(0, 6));
      gd = 16'($urandom_range(0, 7));
      v  = ($urandom_range(0, 9) < 7);
      r  = 9'($urandom_range(0, 511));
      applyStimulus(st, ab, nm, gd, v, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
